// File: rtl/tx_fifo_pkg.sv
// Shared types and constants for the I2S transmit FIFO and its serializer.
package tx_fifo_pkg;

    typedef enum logic [1:0] {
        STD_PHILIPS = 2'b00,
        STD_LEFT    = 2'b01,
        STD_RIGHT   = 2'b10
    } std_e;

    localparam logic [1:0]  MODE_MASTER_TX = 2'b11;
    localparam int unsigned DEF_DEPTH      = 8;
    localparam int unsigned DEF_WIDTH      = 32;

    // The reserved encoding 2'b11 falls back to Philips framing.
    function automatic std_e decode_std(input logic [1:0] code);
        std_e s;
        case (code)
            2'b01:   s = STD_LEFT;
            2'b10:   s = STD_RIGHT;
            default: s = STD_PHILIPS;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/i2s_serializer.sv
// I2S slot serializer: bit counter, word-select generation and slot shift register.
// Requests a FIFO pop at each slot boundary that needs a fresh word.
module i2s_serializer
    import tx_fifo_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             active,
    input  logic             stereo,
    input  logic [1:0]       standard,
    input  logic             frame_size,
    input  logic [WIDTH-1:0] head_word,
    input  logic             head_valid,
    output logic             pop_req,
    output logic             dout,
    output logic             ws
);

    logic [5:0]       cnt_q, cnt_d;
    logic             s32_q, s32_d;
    logic             stereo_q, stereo_d;
    std_e             std_q, std_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic             dout_q, dout_d;
    logic             ws_q, ws_d;

    logic             frame_start, right_start, slot_start;
    logic             s32_eff, stereo_eff;
    std_e             std_eff;
    logic [5:0]       slot_len, last_cnt;
    logic [WIDTH-1:0] fresh_word, slot_word, aligned;

    // Configuration is sampled live at cnt==0 and held for the rest of the frame.
    always_comb begin
        frame_start = (cnt_q == 6'd0);
        s32_eff     = frame_start ? frame_size : s32_q;
        stereo_eff  = frame_start ? stereo : stereo_q;
        std_eff     = frame_start ? decode_std(standard) : std_q;
        slot_len    = s32_eff ? 6'd32 : 6'd16;
        last_cnt    = s32_eff ? 6'd63 : 6'd31;
        right_start = (cnt_q == slot_len);
        slot_start  = active && (frame_start || right_start);
        pop_req     = active && (frame_start || (stereo_eff && right_start));

        if (!head_valid) begin
            fresh_word = '0;
        end else if (!s32_eff) begin
            fresh_word = {{(WIDTH-16){1'b0}}, head_word[15:0]};
        end else if (std_eff == STD_RIGHT) begin
            fresh_word = {{(WIDTH-24){1'b0}}, head_word[23:0]};
        end else begin
            fresh_word = head_word;
        end

        slot_word = pop_req ? fresh_word : word_q;
        aligned   = s32_eff ? slot_word : (slot_word << (WIDTH-16));
    end

    always_comb begin
        cnt_d    = '0;
        s32_d    = s32_q;
        stereo_d = stereo_q;
        std_d    = std_q;
        word_d   = word_q;
        sh_d     = sh_q;
        dout_d   = 1'b0;
        ws_d     = 1'b0;

        if (active) begin
            cnt_d = (cnt_q == last_cnt) ? 6'd0 : cnt_q + 6'd1;
            if (frame_start) begin
                s32_d    = frame_size;
                stereo_d = stereo;
                std_d    = std_eff;
            end

            if (std_eff == STD_PHILIPS) begin
                ws_d = (cnt_q >= slot_len - 6'd1) && (cnt_q != last_cnt);
            end else begin
                ws_d = (cnt_q >= slot_len);
            end

            // Philips delays data by one bit: slot bit 0 is the previous word's LSB.
            if (slot_start) begin
                word_d = slot_word;
                if (std_eff == STD_PHILIPS) begin
                    dout_d = word_q[0];
                    sh_d   = aligned;
                end else begin
                    dout_d = aligned[WIDTH-1];
                    sh_d   = aligned << 1;
                end
            end else begin
                dout_d = sh_q[WIDTH-1];
                sh_d   = sh_q << 1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            s32_q    <= 1'b0;
            stereo_q <= 1'b0;
            std_q    <= STD_PHILIPS;
            word_q   <= '0;
            sh_q     <= '0;
            dout_q   <= 1'b0;
            ws_q     <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            s32_q    <= s32_d;
            stereo_q <= stereo_d;
            std_q    <= std_d;
            word_q   <= word_d;
            sh_q     <= sh_d;
            dout_q   <= dout_d;
            ws_q     <= ws_d;
        end
    end

    assign dout = dout_q;
    assign ws   = ws_q;

endmodule

// File: rtl/tx_fifo.sv
// I2S transmit FIFO with MSB-first serializer and word-select generation.
// Define TX_FIFO_STATUS_EN to expose the full/empty status ports.
module tx_fifo
    import tx_fifo_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_DEPTH,
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wen,
    input  logic [WIDTH-1:0] din,
    input  logic             stereo,
    input  logic [1:0]       standard,
    input  logic [1:0]       mode,
    input  logic             frame_size,
    output logic             dout,
    output logic             ws
`ifdef TX_FIFO_STATUS_EN
    ,
    output logic             full,
    output logic             empty
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;

    logic is_full, is_empty;
    logic pop_req, do_pop, do_push;
    logic active;

    assign active   = (mode == MODE_MASTER_TX);
    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == (PTR_W+1)'(DEPTH));
    assign do_pop   = pop_req && !is_empty;
    // A pop in the same cycle frees a slot, so a write to a full FIFO is still taken.
    assign do_push  = wen && (!is_full || do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    i2s_serializer #(
        .WIDTH(WIDTH)
    ) u_ser (
        .clk       (clk),
        .rst       (rst),
        .active    (active),
        .stereo    (stereo),
        .standard  (standard),
        .frame_size(frame_size),
        .head_word (mem_q[rd_ptr_q]),
        .head_valid(!is_empty),
        .pop_req   (pop_req),
        .dout      (dout),
        .ws        (ws)
    );

`ifdef TX_FIFO_STATUS_EN
    assign full  = is_full;
    assign empty = is_empty;
`endif

endmodule

// File: tb/tb_tx_fifo.sv
// Self-checking bench for tx_fifo: queue-based FIFO model plus per-frame expected bit streams.
`timescale 1ns/1ps
module tb_tx_fifo;

    logic        clk = 1'b0;
    logic        rst, wen, stereo, frame_size, dout, ws;
    logic [31:0] din;
    logic [1:0]  standard, mode;
    logic        st_full, st_empty;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [31:0] mq[$];
    int          n_push, n_pop;
    logic        prev_lsb;

    always #5 clk = ~clk;

    tx_fifo #(
        .DEPTH(8),
        .WIDTH(32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wen       (wen),
        .din       (din),
        .stereo    (stereo),
        .standard  (standard),
        .mode      (mode),
        .frame_size(frame_size),
        .dout      (dout),
        .ws        (ws)
`ifdef TX_FIFO_STATUS_EN
        ,
        .full      (st_full),
        .empty     (st_empty)
`endif
    );

`ifndef TX_FIFO_STATUS_EN
    assign st_full  = (dut.count_q == 4'd8);
    assign st_empty = (dut.count_q == 4'd0);
`endif

    task automatic do_reset();
        wen  = 1'b0;
        mode = 2'b00;
        rst  = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        mq.delete();
        n_push   = 0;
        n_pop    = 0;
        prev_lsb = 1'b0;
    endtask

    task automatic write_word(input logic [31:0] w);
        din = w;
        wen = 1'b1;
        @(posedge clk);
        #1 wen = 1'b0;
        if (mq.size() < 8) begin
            mq.push_back(w);
            n_push++;
        end
    endtask

    function automatic logic [31:0] slot_data(input logic [31:0] raw);
        if (!frame_size) return {16'h0, raw[15:0]};
        if (standard == 2'b10) return {8'h0, raw[23:0]};
        return raw;
    endfunction

    task automatic model_pop(output logic [31:0] d);
        logic [31:0] raw;
        raw = '0;
        if (mq.size() > 0) begin
            raw = mq.pop_front();
            n_pop++;
        end
        d = slot_data(raw);
    endtask

    // Runs whole frames with mode=11; optional single write before edge wr_cycle.
    task automatic run_stream(input int nframes, input int wr_cycle, input logic [31:0] wr_word,
                              input string tag);
        int          s, f2;
        logic        philips;
        logic [31:0] lw, rw;
        logic [63:0] od, ow, ed, ew;
        s       = frame_size ? 32 : 16;
        f2      = 2 * s;
        philips = (standard == 2'b00) || (standard == 2'b11);
        mode    = 2'b11;
        for (int f = 0; f < nframes; f++) begin
            od = '0; ow = '0; ed = '0; ew = '0; lw = '0; rw = '0;
            for (int c = 0; c < f2; c++) begin
                if (f * f2 + c == wr_cycle) begin
                    din = wr_word;
                    wen = 1'b1;
                end
                @(posedge clk);
                #1 wen = 1'b0;
                od[c] = dout;
                ow[c] = ws;
                if (c == 0) model_pop(lw);
                if (c == s) begin
                    if (stereo) model_pop(rw);
                    else rw = lw;
                end
                if (f * f2 + c == wr_cycle && mq.size() < 8) begin
                    mq.push_back(wr_word);
                    n_push++;
                end
            end
            for (int k = 0; k < s; k++) begin
                if (philips) begin
                    if (k == 0) begin
                        ed[0] = prev_lsb;
                        ed[s] = lw[0];
                    end else begin
                        ed[k]     = lw[s-k];
                        ed[s+k]   = rw[s-k];
                    end
                    ew[k]   = (k == s - 1);
                    ew[s+k] = (k != s - 1);
                end else begin
                    ed[k]   = lw[s-1-k];
                    ed[s+k] = rw[s-1-k];
                    ew[k]   = 1'b0;
                    ew[s+k] = 1'b1;
                end
            end
            prev_lsb = rw[0];
            tests_run++;
            if (od !== ed) begin
                tests_failed++;
                $display("FAIL %s_dout frame %0d: got %h expected %h", tag, f, od, ed);
            end
            tests_run++;
            if (ow !== ew) begin
                tests_failed++;
                $display("FAIL %s_ws frame %0d: got %h expected %h", tag, f, ow, ew);
            end
        end
        mode = 2'b00;
    endtask

    task automatic check_ptrs(input string tag);
        tests_run++;
        if (dut.wr_ptr_q !== 3'(n_push % 8) || dut.rd_ptr_q !== 3'(n_pop % 8)) begin
            tests_failed++;
            $display("FAIL %s_ptrs: got wr=%0d rd=%0d expected wr=%0d rd=%0d", tag,
                     dut.wr_ptr_q, dut.rd_ptr_q, n_push % 8, n_pop % 8);
        end
        tests_run++;
        if (st_empty !== (mq.size() == 0) || st_full !== (mq.size() == 8)) begin
            tests_failed++;
            $display("FAIL %s_status: got full=%b empty=%b expected full=%b empty=%b", tag,
                     st_full, st_empty, mq.size() == 8, mq.size() == 0);
        end
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 3; i++) write_word($urandom);
        do_reset();
        for (int i = 0; i < 8; i++) begin
            tests_run++;
            if (dut.mem_q[i] !== 32'h0) begin
                tests_failed++;
                $display("FAIL reset_mem[%0d]: got %h expected 00000000", i, dut.mem_q[i]);
            end
        end
        tests_run++;
        if (dout !== 1'b0 || ws !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_out: got dout=%b ws=%b expected 0 0", dout, ws);
        end
        check_ptrs("reset");
    endtask

    task automatic test_stereo_rj();
        do_reset();
        stereo = 1'b1; standard = 2'b10; frame_size = 1'b1;
        for (int i = 0; i < 8; i++) write_word((i % 2 == 0) ? 32'hFFFF_FFFF : 32'h0);
        write_word(32'h0);
        run_stream(5, -1, 32'h0, "stereo_rj");
        check_ptrs("stereo_rj");
    endtask

    task automatic test_philips16();
        do_reset();
        stereo = 1'b1; standard = 2'b00; frame_size = 1'b0;
        write_word(32'h0000_A5A5);
        run_stream(2, -1, 32'h0, "philips16");
    endtask

    task automatic test_mono();
        do_reset();
        stereo = 1'b0; standard = 2'b01; frame_size = 1'b1;
        write_word(32'h8000_0000);
        write_word(32'h1234_5678);
        run_stream(1, -1, 32'h0, "mono0");
        check_ptrs("mono");
        run_stream(1, -1, 32'h0, "mono1");
    endtask

    task automatic test_overflow();
        logic [31:0] first;
        do_reset();
        stereo = 1'b1; standard = 2'b01; frame_size = 1'b1;
        first = $urandom;
        write_word(first);
        for (int i = 1; i < 8; i++) write_word($urandom);
        check_ptrs("ovf_full");
        write_word($urandom);
        check_ptrs("ovf_drop");
        tests_run++;
        if (dut.mem_q[0] !== first) begin
            tests_failed++;
            $display("FAIL ovf_entry0: got %h expected %h", dut.mem_q[0], first);
        end
        // Write coinciding with the first pop while full must be accepted; wraps to entry 0.
        run_stream(5, 0, $urandom, "ovf_stream");
        check_ptrs("ovf_wrap");
    endtask

    task automatic test_underflow();
        do_reset();
        stereo = 1'b1; standard = 2'b01; frame_size = 1'b0;
        run_stream(1, -1, 32'h0, "udf_empty");
        check_ptrs("udf_empty");
        run_stream(2, 5, $urandom, "udf_late");
        check_ptrs("udf_late");
    endtask

    task automatic test_random();
        int nw;
        for (int it = 0; it < 4; it++) begin
            do_reset();
            stereo     = 1'($urandom_range(0, 1));
            standard   = 2'($urandom_range(0, 3));
            frame_size = 1'($urandom_range(0, 1));
            nw = $urandom_range(1, 9);
            for (int i = 0; i < nw; i++) write_word($urandom);
            run_stream(4, $urandom_range(0, 40), $urandom, "random");
            check_ptrs("random");
        end
    endtask

    initial begin
        rst = 1'b0; wen = 1'b0; din = '0; mode = 2'b00;
        stereo = 1'b1; standard = 2'b00; frame_size = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_stereo_rj();
        test_philips16();
        test_mono();
        test_overflow();
        test_underflow();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
